// File: rtl/program_counter_unit.sv
// Fetch-stage program counter: sequential advance, stall hold, branch/jump
// redirect with same-cycle flush, saturating redirect counters and a sticky
// misaligned-branch flag.
module program_counter_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [1:0]           PCSrc,
  input  logic                 ResolveValid,
  input  logic [31:0]          BranchTarget,
  input  logic [25:0]          JumpIndex,
  input  logic [31:0]          ResolvePCPlus4,
  input  logic                 Stall,
  output logic [31:0]          PC,
  output logic [31:0]          PCPlus4,
  output logic                 Flush,
  output logic [CNT_WIDTH-1:0] BranchTakenCount,
  output logic [CNT_WIDTH-1:0] JumpCount,
  output logic                 AlignErr
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic        take_jump;
  logic        branch_req;
  logic        take_branch;
  logic        branch_misaligned;
  logic        redirect;
  logic [31:0] jump_target;
  logic [31:0] redirect_target;
  logic [31:0] pc_next;

  // Only the region bits of the resolving PC+4 feed the jump target.
  logic unused_pcplus4_bits;
  assign unused_pcplus4_bits = ^ResolvePCPlus4[27:0];

  assign PCPlus4 = PC + 32'd4;

  // Redirect decode: jump wins over branch; misaligned branches are rejected.
  always_comb begin
    take_jump         = ResolveValid & PCSrc[1];
    branch_req        = ResolveValid & ~PCSrc[1] & PCSrc[0];
    take_branch       = branch_req & (BranchTarget[1:0] == 2'b00);
    branch_misaligned = branch_req & (BranchTarget[1:0] != 2'b00);
    redirect          = take_jump | take_branch;
    jump_target       = {ResolvePCPlus4[31:28], JumpIndex, 2'b00};
    redirect_target   = take_jump ? jump_target : BranchTarget;
    Flush             = redirect & ~Reset;
  end

  // Next-PC selection: redirect overrides stall, otherwise stall holds.
  always_comb begin
    pc_next = PCPlus4;
    if (redirect) begin
      pc_next = redirect_target;
    end else if (Stall) begin
      pc_next = PC;
    end
  end

  // PC register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      PC <= RESET_PC;
    end else begin
      PC <= pc_next;
    end
  end

  // Saturating redirect counters and sticky misalignment flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      BranchTakenCount <= '0;
      JumpCount        <= '0;
      AlignErr         <= 1'b0;
    end else begin
      if (take_branch && (BranchTakenCount != '1)) begin
        BranchTakenCount <= BranchTakenCount + CNT_ONE;
      end
      if (take_jump && (JumpCount != '1)) begin
        JumpCount <= JumpCount + CNT_ONE;
      end
      if (branch_misaligned) begin
        AlignErr <= 1'b1;
      end
    end
  end

endmodule

// File: doc/program_counter_unit.md
# program_counter_unit

Fetch-stage program counter with next-PC selection, consuming the 2-bit `PCSrc` produced by the branch-resolution AND stage. Holds the architectural PC and advances it by 4 each cycle. It redirects to a branch or jump target when a qualified resolution arrives, honours pipeline stalls, and raises a same-cycle flush for the wrong-path fetch/decode registers. It also keeps saturating taken-branch and jump counters and a sticky misaligned-target flag for debug.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `CNT_WIDTH`, default 16: width of each performance counter.

Ports:
- `Clk`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  reset, synchronous and active-high.
- `PCSrc`  in  2  from the branch AND stage: bit 1 = jump; bit 0 = branch taken (branch AND zero).
- `ResolveValid`  in  1  qualifies `PCSrc`; `PCSrc` is ignored when 0.
- `BranchTarget`  in  32  fully formed branch target address.
- `JumpIndex`  in  26  instruction index field of the resolving jump.
- `ResolvePCPlus4`  in  32  PC+4 of the resolving instruction; supplies jump upper bits.
- `Stall`  in  1  hold the PC (hazard unit).
- `PC`  out  32  current fetch address, registered.
- `PCPlus4`  out  32  `PC + 4`, combinational.
- `Flush`  out  1  combinational; asserted in the cycle a redirect is accepted.
- `BranchTakenCount`  out  CNT_WIDTH  accepted branch redirects, saturating.
- `JumpCount`  out  CNT_WIDTH  accepted jump redirects, saturating.
- `AlignErr`  out  1  sticky; set when a branch target is misaligned.

## Operation
- Jump target is `{ResolvePCPlus4[31:28], JumpIndex, 2'b00}`. It is always word-aligned.
- Redirect decode applies only when `ResolveValid=1`. When `ResolveValid=0`, the unit behaves as `PCSrc=00`.
  - `PCSrc[1]=1`: jump. This takes priority over bit 0, so `PCSrc=11` is a jump.
  - `PCSrc=01`: branch taken, but only if `BranchTarget[1:0]==2'b00`.
  - `PCSrc=01` with a misaligned target: the redirect is rejected. The cycle is treated as sequential, `AlignErr` is set, `Flush` stays 0, and no counter changes.
  - `PCSrc=00`: sequential.
- Next-PC priority, highest first:
  1. `Reset`: PC ← `RESET_PC`.
  2. Accepted redirect: PC ← target.
  3. `Stall`: PC holds.
  4. Otherwise: PC ← `PCPlus4`.
- A redirect overrides `Stall`. The resolving instruction is older than the stalled one, and the wrong-path instructions are flushed anyway.
- `Flush = accepted redirect`. It is independent of `Stall` and forced to 0 while `Reset=1`.
- Counters: +1 on each accepted redirect of their type. They hold at all-ones, with no wrap.
- `AlignErr` clears only on `Reset`.

## Timing
- All outputs are 0 on reset except `PC=RESET_PC` and `PCPlus4=RESET_PC+4`. `Flush=0`, both counters 0, `AlignErr=0`.
- Redirect latency is 1 cycle. Inputs are sampled at edge N, and `PC` shows the target after edge N. `Flush` is high during the cycle before edge N, so the IF/ID and ID/EX registers clear on the same edge that loads the target.
- Sequential fetch advances `PC` by 4 per unstalled edge.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000. `PCPlus4` wraps the same way.
- `PCSrc` may glitch while `ResolveValid=0`. Only values present at the edge while `ResolveValid=1` matter.
- Reset asserted mid-redirect (same cycle as a valid redirect): reset wins. The PC loads `RESET_PC`, and no counter or flag updates.
- Back-to-back redirects on consecutive cycles are each accepted independently. The second target overwrites the first.

## Test plan
- Reset then 4 free-running cycles, no stall: `PC` sequence 0, 4, 8, 12, 16. `Flush` stays 0. Counters stay 0.
- At `PC=0x20`, drive `ResolveValid=1`, `PCSrc=01`, `BranchTarget=0x100`: `Flush=1` that cycle, next `PC=0x100`, `BranchTakenCount=1`. Repeat with `PCSrc=01` but `ResolveValid=0`: `PC` advances by 4.
- Jump case: `PCSrc=11`, `ResolvePCPlus4=0x40000010`, `JumpIndex=26'h0000040`. Required: next `PC=0x40000100`, `JumpCount=1`, `BranchTakenCount` unchanged.
- Stall conflicts:
  - `Stall=1` for 3 cycles at `PC=0x50`: `PC` holds at 0x50.
  - `Stall=1` together with a valid branch to 0x200: `PC=0x200`, `Flush=1`.
- Misaligned branch: `BranchTarget=0x102`, `PCSrc=01`, valid, at `PC=0x10`. Required: next `PC=0x14`, `AlignErr=1` (still 1 after 10 cycles), `Flush=0`, count unchanged.
- Wrap and saturation:
  - Start at `RESET_PC=0xFFFFFFF8`: `PC` goes FFFFFFF8, FFFFFFFC, 00000000.
  - With `CNT_WIDTH=2`, apply 5 jumps: `JumpCount` is 3 after the third jump and stays 3.
  - Reset asserted during a valid jump: `PC=RESET_PC`, `JumpCount` is not incremented.
